// File: rtl/ram_port_arbiter.sv
// Zero-fill sequencer and round-robin two-port arbiter in front of a 64x8 single-port RAM.
// Read data comes back two cycles after the handshake, tagged with the issuing port.
module ram_port_arbiter #(
    parameter int AW = 6,
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          reset_n,

    input  logic          a_req_valid,
    input  logic          a_req_we,
    input  logic [AW-1:0] a_req_addr,
    input  logic [DW-1:0] a_req_wdata,
    output logic          a_req_ready,
    output logic          a_rsp_valid,
    output logic [DW-1:0] a_rsp_data,

    input  logic          b_req_valid,
    input  logic          b_req_we,
    input  logic [AW-1:0] b_req_addr,
    input  logic [DW-1:0] b_req_wdata,
    output logic          b_req_ready,
    output logic          b_rsp_valid,
    output logic [DW-1:0] b_rsp_data,

    output logic [DW-1:0] ram_data,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    input  logic [DW-1:0] ram_q,

    output logic          busy
);

    // state | meaning
    // RST   | reset state, RAM idle, leaves on the first edge out of reset
    // INIT  | zero-fill: one write per cycle to address init_cnt
    // RUN   | round-robin arbitration between ports A and B
    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    state_t        state_q, state_d;
    logic [AW-1:0] init_cnt_q, init_cnt_d;
    logic          last_grant_q, last_grant_d;
    logic          s1_valid_q, s1_valid_d;
    logic          s1_port_q, s1_port_d;
    logic          a_rsp_valid_q, a_rsp_valid_d;
    logic          b_rsp_valid_q, b_rsp_valid_d;
    logic [DW-1:0] a_rsp_data_q, a_rsp_data_d;
    logic [DW-1:0] b_rsp_data_q, b_rsp_data_d;

    logic          grant_a;
    logic          grant_b;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_RST;
            init_cnt_q    <= '0;
            last_grant_q  <= PORT_B;
            s1_valid_q    <= 1'b0;
            s1_port_q     <= PORT_A;
            a_rsp_valid_q <= 1'b0;
            b_rsp_valid_q <= 1'b0;
            a_rsp_data_q  <= '0;
            b_rsp_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            last_grant_q  <= last_grant_d;
            s1_valid_q    <= s1_valid_d;
            s1_port_q     <= s1_port_d;
            a_rsp_valid_q <= a_rsp_valid_d;
            b_rsp_valid_q <= b_rsp_valid_d;
            a_rsp_data_q  <= a_rsp_data_d;
            b_rsp_data_q  <= b_rsp_data_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        init_cnt_d    = init_cnt_q;
        last_grant_d  = last_grant_q;
        s1_valid_d    = 1'b0;
        s1_port_d     = s1_port_q;
        a_rsp_valid_d = 1'b0;
        b_rsp_valid_d = 1'b0;
        a_rsp_data_d  = a_rsp_data_q;
        b_rsp_data_d  = b_rsp_data_q;
        grant_a       = 1'b0;
        grant_b       = 1'b0;
        ram_we        = 1'b0;
        ram_addr      = '0;
        ram_data      = '0;

        // ram_q is valid the cycle after the read grant; capture it for the owner
        if (s1_valid_q) begin
            if (s1_port_q == PORT_A) begin
                a_rsp_valid_d = 1'b1;
                a_rsp_data_d  = ram_q;
            end else begin
                b_rsp_valid_d = 1'b1;
                b_rsp_data_d  = ram_q;
            end
        end

        case (state_q)
            ST_RST: begin
                state_d    = ST_INIT;
                init_cnt_d = '0;
            end
            ST_INIT: begin
                ram_we     = 1'b1;
                ram_addr   = init_cnt_q;
                ram_data   = '0;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == '1) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                grant_a = a_req_valid && (!b_req_valid || (last_grant_q == PORT_B));
                grant_b = b_req_valid && (!a_req_valid || (last_grant_q == PORT_A));
                if (grant_a) begin
                    ram_we       = a_req_we;
                    ram_addr     = a_req_addr;
                    ram_data     = a_req_wdata;
                    last_grant_d = PORT_A;
                    if (!a_req_we) begin
                        s1_valid_d = 1'b1;
                        s1_port_d  = PORT_A;
                    end
                end else if (grant_b) begin
                    ram_we       = b_req_we;
                    ram_addr     = b_req_addr;
                    ram_data     = b_req_wdata;
                    last_grant_d = PORT_B;
                    if (!b_req_we) begin
                        s1_valid_d = 1'b1;
                        s1_port_d  = PORT_B;
                    end
                end
            end
            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    assign a_req_ready = grant_a;
    assign b_req_ready = grant_b;
    assign a_rsp_valid = a_rsp_valid_q;
    assign b_rsp_valid = b_rsp_valid_q;
    assign a_rsp_data  = a_rsp_data_q;
    assign b_rsp_data  = b_rsp_data_q;
    assign busy        = (state_q != ST_RUN);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM beside the DUT, a cycle model of
// the arbiter's rules checked every cycle, plus directed literal checks.
module tb_ram_port_arbiter;
    localparam int AW = 6;
    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          a_req_valid, a_req_we, a_req_ready, a_rsp_valid;
    logic [AW-1:0] a_req_addr;
    logic [DW-1:0] a_req_wdata, a_rsp_data;
    logic          b_req_valid, b_req_we, b_req_ready, b_rsp_valid;
    logic [AW-1:0] b_req_addr;
    logic [DW-1:0] b_req_wdata, b_rsp_data;
    logic [DW-1:0] ram_data, ram_q;
    logic [AW-1:0] ram_addr;
    logic          ram_we, busy;

    always #5 clock = ~clock;

    // single-port RAM: registered address, write on the edge
    logic [DW-1:0] ram [64];
    logic [AW-1:0] addr_reg;
    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 8'hA5;
        addr_reg = '0;
    end
    always @(posedge clock) begin
        if (ram_we) ram[ram_addr] <= ram_data;
        addr_reg <= ram_addr;
    end
    assign ram_q = ram[addr_reg];

    ram_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clock(clock), .reset_n(reset_n),
        .a_req_valid(a_req_valid), .a_req_we(a_req_we), .a_req_addr(a_req_addr),
        .a_req_wdata(a_req_wdata), .a_req_ready(a_req_ready),
        .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
        .b_req_valid(b_req_valid), .b_req_we(b_req_we), .b_req_addr(b_req_addr),
        .b_req_wdata(b_req_wdata), .b_req_ready(b_req_ready),
        .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
        .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q),
        .busy(busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         due;
        bit         port;
        logic [7:0] data;
    } rsp_t;

    int         m_since;
    bit         m_last;
    logic [7:0] m_mem [64];
    logic [7:0] m_rsp [2];
    rsp_t       pend [$];
    bit         ev_a, ev_b, ga, gb;
    logic [7:0] e_data;
    int         e_addr;
    bit         e_we;

    always @(negedge clock) begin
        cyc++;
        if (!reset_n) begin
            m_since  = 0;
            m_last   = 1'b1;
            pend.delete();
            m_rsp[0] = 8'h00;
            m_rsp[1] = 8'h00;
            chk("rst_busy", busy, 1);
            chk("rst_ram_we", ram_we, 0);
            chk("rst_ram_addr", ram_addr, 0);
            chk("rst_ram_data", ram_data, 0);
            chk("rst_a_ready", a_req_ready, 0);
            chk("rst_b_ready", b_req_ready, 0);
            chk("rst_a_rsp_valid", a_rsp_valid, 0);
            chk("rst_b_rsp_valid", b_rsp_valid, 0);
            chk("rst_a_rsp_data", a_rsp_data, 0);
            chk("rst_b_rsp_data", b_rsp_data, 0);
        end else begin
            ev_a = 0;
            ev_b = 0;
            while (pend.size() > 0 && pend[0].due == cyc) begin
                if (pend[0].port) begin ev_b = 1; m_rsp[1] = pend[0].data; end
                else              begin ev_a = 1; m_rsp[0] = pend[0].data; end
                void'(pend.pop_front());
            end
            ga = 0; gb = 0; e_we = 0; e_addr = 0; e_data = 8'h00;
            if (m_since == 0) begin
                chk("m_busy", busy, 1);
            end else if (m_since <= 64) begin
                e_we   = 1;
                e_addr = m_since - 1;
                m_mem[e_addr] = 8'h00;
                chk("m_busy", busy, 1);
            end else begin
                ga = a_req_valid && (!b_req_valid || m_last);
                gb = b_req_valid && !ga;
                if (ga) begin
                    e_we = a_req_we; e_addr = a_req_addr; e_data = a_req_wdata; m_last = 0;
                end else if (gb) begin
                    e_we = b_req_we; e_addr = b_req_addr; e_data = b_req_wdata; m_last = 1;
                end
                if (ga || gb) begin
                    if (e_we) m_mem[e_addr] = e_data;
                    else pend.push_back('{due: cyc + 2, port: gb, data: m_mem[e_addr]});
                end
                chk("m_busy", busy, 0);
            end
            chk("m_a_ready", a_req_ready, ga);
            chk("m_b_ready", b_req_ready, gb);
            chk("m_ram_we", ram_we, e_we);
            chk("m_ram_addr", ram_addr, e_addr);
            chk("m_ram_data", ram_data, e_data);
            chk("m_a_rsp_valid", a_rsp_valid, ev_a);
            chk("m_b_rsp_valid", b_rsp_valid, ev_b);
            chk("m_a_rsp_data", a_rsp_data, m_rsp[0]);
            chk("m_b_rsp_data", b_rsp_data, m_rsp[1]);
            if (m_since < 1000) m_since++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic set_a(input bit v, input bit we, input int addr, input int wd);
        a_req_valid = v; a_req_we = we; a_req_addr = addr[5:0]; a_req_wdata = wd[7:0];
    endtask

    task automatic set_b(input bit v, input bit we, input int addr, input int wd);
        b_req_valid = v; b_req_we = we; b_req_addr = addr[5:0]; b_req_wdata = wd[7:0];
    endtask

    task automatic wait_init();
        int  we_cnt;
        bit  done;
        we_cnt = 0;
        done   = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (!busy) begin done = 1; break; end
            if (ram_we) we_cnt++;
        end
        chk("init_done", done, 1);
        chk("init_we_cycles", we_cnt, 64);
    endtask

    bit a_x, b_x;

    initial begin
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        reset_n = 1'b0;
        repeat (3) next();
        reset_n = 1'b1;
        wait_init();

        // read of a zero-filled location
        next(); set_a(1, 0, 37, 0);
        @(negedge clock); chk("rd37_ready", a_req_ready, 1);
        next(); set_a(0, 0, 0, 0);
        next();
        @(negedge clock);
        chk("rd37_valid", a_rsp_valid, 1);
        chk("rd37_data", a_rsp_data, 8'h00);

        // write then read next cycle
        next(); set_a(1, 1, 12, 8'h5A);
        next(); set_a(1, 0, 12, 0);
        next(); set_a(0, 0, 0, 0);
        next();
        @(negedge clock);
        chk("raw_valid", a_rsp_valid, 1);
        chk("raw_data", a_rsp_data, 8'h5A);

        // round-robin: preload, leave last grant on B
        next(); set_a(1, 1, 1, 8'h11);
        @(negedge clock); chk("pre_a_ready", a_req_ready, 1);
        next(); set_a(0, 0, 0, 0); set_b(1, 1, 2, 8'h22);
        @(negedge clock); chk("pre_b_ready", b_req_ready, 1);
        for (int k = 0; k < 6; k++) begin
            next();
            if (k < 4) begin set_a(1, 0, 1, 0); set_b(1, 0, 2, 0); end
            else begin set_a(0, 0, 0, 0); set_b(0, 0, 0, 0); end
            @(negedge clock);
            if (k < 4) begin
                chk("rr_a_ready", a_req_ready, (k % 2 == 0));
                chk("rr_b_ready", b_req_ready, (k % 2 == 1));
            end
            if (k >= 2) begin
                chk("rr_a_rsp_valid", a_rsp_valid, (k % 2 == 0));
                chk("rr_b_rsp_valid", b_rsp_valid, (k % 2 == 1));
                if (k % 2 == 0) chk("rr_a_rsp_data", a_rsp_data, 8'h11);
                else            chk("rr_b_rsp_data", b_rsp_data, 8'h22);
            end
        end

        // stall hold with last grant on A
        next(); set_a(1, 1, 5, 8'h55);
        @(negedge clock); chk("st_pre_ready", a_req_ready, 1);
        next(); set_a(1, 0, 5, 0); set_b(1, 1, 6, 8'h66);
        @(negedge clock);
        chk("st_b_ready", b_req_ready, 1);
        chk("st_a_wait", a_req_ready, 0);
        chk("st_b_addr", ram_addr, 6);
        next(); set_b(0, 0, 0, 0);
        @(negedge clock);
        chk("st_a_ready", a_req_ready, 1);
        chk("st_a_addr", ram_addr, 5);
        chk("st_a_we", ram_we, 0);
        next(); set_a(0, 0, 0, 0);
        next();
        @(negedge clock);
        chk("st_a_rsp_valid", a_rsp_valid, 1);
        chk("st_a_rsp_data", a_rsp_data, 8'h55);

        // B alone: 64 writes of ~addr, then 64 reads
        for (int k = 0; k < 64; k++) begin
            next(); set_b(1, 1, k, ~k);
            @(negedge clock); chk("sb_wr_ready", b_req_ready, 1);
        end
        for (int k = 0; k < 66; k++) begin
            next();
            if (k < 64) set_b(1, 0, k, 0); else set_b(0, 0, 0, 0);
            @(negedge clock);
            if (k < 64) chk("sb_rd_ready", b_req_ready, 1);
            if (k >= 2) begin
                chk("sb_rsp_valid", b_rsp_valid, 1);
                chk("sb_rsp_data", b_rsp_data, (~(k - 2)) & 255);
            end
        end

        // reset one cycle after a read handshake
        next(); set_b(0, 0, 0, 0); set_a(1, 1, 9, 8'h99);
        next(); set_a(1, 0, 9, 0);
        @(negedge clock); chk("mr_ready", a_req_ready, 1);
        next(); set_a(0, 0, 0, 0); reset_n = 1'b0;
        @(negedge clock); chk("mr_no_rsp0", a_rsp_valid, 0);
        next();
        @(negedge clock); chk("mr_no_rsp1", a_rsp_valid, 0);
        next(); reset_n = 1'b1;
        wait_init();
        next(); set_a(1, 0, 9, 0);
        next(); set_a(0, 0, 0, 0);
        next();
        @(negedge clock);
        chk("mr_rd_valid", a_rsp_valid, 1);
        chk("mr_rd_data", a_rsp_data, 8'h00);

        // random traffic obeying the hold rule
        a_x = 0; b_x = 0;
        for (int c = 0; c < 1500; c++) begin
            next();
            if (!a_req_valid || a_x) begin
                a_req_valid = ($urandom_range(0, 3) != 0);
                a_req_we    = 1'($urandom_range(0, 1));
                a_req_addr  = 6'($urandom_range(0, 15));
                a_req_wdata = 8'($urandom);
            end
            if (!b_req_valid || b_x) begin
                b_req_valid = ($urandom_range(0, 3) != 0);
                b_req_we    = 1'($urandom_range(0, 1));
                b_req_addr  = 6'($urandom_range(0, 15));
                b_req_wdata = 8'($urandom);
            end
            @(negedge clock);
            a_x = a_req_valid && a_req_ready;
            b_x = b_req_valid && b_req_ready;
        end
        next(); set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
        repeat (4) next();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
